// File: rtl/handshake_recv_buffer.sv
// Two-slot elastic receive buffer with registered valid/ready outputs on both channel ends.
// Optional constant-match monitor enabled by defining HANDSHAKE_RECV_BUFFER_CONST_MATCH_EN.
module handshake_recv_buffer #(
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0]  CONST_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
`ifdef HANDSHAKE_RECV_BUFFER_CONST_MATCH_EN
  output logic                  mismatch,
  output logic [15:0]           match_count,
`endif
  input  logic                  outs_ready
);

  logic [1:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0] slot0_q, slot0_d;
  logic [DATA_WIDTH-1:0] slot1_q, slot1_d;
  logic                  push, pop;

  // Ready and valid come straight from the occupancy register.
  assign ins_ready  = (count_q != 2'd2);
  assign outs_valid = (count_q != 2'd0);
  assign outs       = slot0_q;

  assign push = ins_valid && ins_ready;
  assign pop  = outs_valid && outs_ready;

  always_comb begin
    count_d = count_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          slot0_d = ins;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          slot0_d = ins;
        end else if (push) begin
          slot1_d = ins;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          slot0_d = slot1_q;
          count_d = 2'd1;
        end
      end
      default: count_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      slot0_q <= '0;
    end else begin
      count_q <= count_d;
      slot0_q <= slot0_d;
    end
  end

  // The tail slot is only read when occupied, so it needs no reset.
  always_ff @(posedge clk) begin
    slot1_q <= slot1_d;
  end

`ifdef HANDSHAKE_RECV_BUFFER_CONST_MATCH_EN
  logic        mismatch_q, mismatch_d;
  logic [15:0] match_count_q, match_count_d;

  always_comb begin
    mismatch_d    = mismatch_q;
    match_count_d = match_count_q;
    if (push) begin
      if (ins == CONST_VALUE) begin
        if (match_count_q != 16'hFFFF) begin
          match_count_d = match_count_q + 16'd1;
        end
      end else begin
        mismatch_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_q    <= 1'b0;
      match_count_q <= 16'd0;
    end else begin
      mismatch_q    <= mismatch_d;
      match_count_q <= match_count_d;
    end
  end

  assign mismatch    = mismatch_q;
  assign match_count = match_count_q;
`endif

endmodule

// File: tb/tb_handshake_recv_buffer.sv
// Self-checking bench for handshake_recv_buffer: directed steps plus a random stream, all
// compared cycle by cycle against a queue-based model of a two-entry FIFO.
module tb_handshake_recv_buffer;

  localparam int unsigned W = 18;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] ins;
  logic         ins_valid;
  logic         ins_ready;
  logic [W-1:0] outs;
  logic         outs_valid;
  logic         outs_ready;
`ifdef HANDSHAKE_RECV_BUFFER_CONST_MATCH_EN
  logic         mismatch;
  logic [15:0]  match_count;
`endif

  handshake_recv_buffer #(
    .DATA_WIDTH  (W),
    .CONST_VALUE (18'h3FC4E)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ins         (ins),
    .ins_valid   (ins_valid),
    .ins_ready   (ins_ready),
    .outs        (outs),
    .outs_valid  (outs_valid),
`ifdef HANDSHAKE_RECV_BUFFER_CONST_MATCH_EN
    .mismatch    (mismatch),
    .match_count (match_count),
`endif
    .outs_ready  (outs_ready)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model: a bounded FIFO of at most two tokens.
  logic [W-1:0] q[$];
  logic         zero_head;
  logic         acc;
  logic [15:0]  m_count;
  logic         m_mismatch;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [W-1:0] d, input logic v, input logic o);
    logic do_push, do_pop;
    @(negedge clk);
    rst        = r;
    ins        = d;
    ins_valid  = v;
    outs_ready = o;
    @(posedge clk);
    acc = 1'b0;
    if (r) begin
      q.delete();
      zero_head  = 1'b1;
      m_count    = 16'd0;
      m_mismatch = 1'b0;
    end else begin
      do_pop  = (q.size() != 0) && o;
      do_push = v && (q.size() < 2);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back(d);
        zero_head = 1'b0;
        acc       = 1'b1;
        if (d == 18'h3FC4E) begin
          if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
        end else begin
          m_mismatch = 1'b1;
        end
      end
    end
    #1;
    check("ins_ready", {31'd0, ins_ready}, {31'd0, q.size() != 2});
    check("outs_valid", {31'd0, outs_valid}, {31'd0, q.size() != 0});
    if (q.size() != 0) check("outs", {14'd0, outs}, {14'd0, q[0]});
    else if (zero_head) check("outs_zero", {14'd0, outs}, 32'd0);
`ifdef HANDSHAKE_RECV_BUFFER_CONST_MATCH_EN
    check("match_count", {16'd0, match_count}, {16'd0, m_count});
    check("mismatch", {31'd0, mismatch}, {31'd0, m_mismatch});
`endif
  endtask

  initial begin
    logic [W-1:0] stream [3];
    logic [W-1:0] d;
    logic         v;
    int           sent;
    int           cyc;

    rst = 1'b1; ins = '0; ins_valid = 1'b0; outs_ready = 1'b0;
    zero_head = 1'b1; acc = 1'b0; m_count = 16'd0; m_mismatch = 1'b0;

    // Reset held with a token offered; nothing may be captured.
    step(1'b1, 18'h3FC4E, 1'b1, 1'b1);
    step(1'b1, 18'h3FC4E, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);

    // Back-to-back streaming with the consumer always ready.
    stream[0] = 18'h3FC4E; stream[1] = 18'h00001; stream[2] = 18'h2AAAA;
    for (int i = 0; i < 3; i++) step(1'b0, stream[i], 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b0, 1'b1);

    // Backpressure: two tokens absorbed, third held until space frees up.
    step(1'b0, 18'h0000A, 1'b1, 1'b0);
    step(1'b0, 18'h0000B, 1'b1, 1'b0);
    check("bp_full", {31'd0, ins_ready}, 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 18'h0000C, 1'b1, 1'b0);
    check("bp_c_held", {31'd0, acc}, 32'd0);
    cyc = 0;
    do begin
      step(1'b0, 18'h0000C, 1'b1, 1'b1);
      cyc++;
    end while (!acc && cyc < 10);
    check("bp_c_accepted", {31'd0, acc}, 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 'x, 1'b0, 1'b1);

    // Random stream with random backpressure; X on ins whenever ins_valid is low.
    sent = 0;
    cyc  = 0;
    d    = W'($urandom);
    while (sent < 1000 && cyc < 20000) begin
      v = ($urandom_range(0, 3) != 0);
      step(1'b0, v ? d : 'x, v, 1'($urandom_range(0, 1)));
      if (acc) begin
        sent++;
        d = W'($urandom);
      end
      cyc++;
    end
    check("rand_sent", sent, 1000);
    for (int i = 0; i < 4; i++) step(1'b0, 'x, 1'b0, 1'b1);

    // Reset with the buffer full: both tokens must vanish.
    step(1'b0, 18'h11111, 1'b1, 1'b0);
    step(1'b0, 18'h22222, 1'b1, 1'b0);
    check("full_before_rst", {31'd0, outs_valid}, 32'd1);
    step(1'b1, 18'h33333, 1'b1, 1'b1);
    check("rst_mid_valid", {31'd0, outs_valid}, 32'd0);
    check("rst_mid_ready", {31'd0, ins_ready}, 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 'x, 1'b0, 1'b1);

    // Constant matcher: three matches then a mismatch.
    for (int i = 0; i < 3; i++) step(1'b0, 18'h3FC4E, 1'b1, 1'b1);
    step(1'b0, 18'h00000, 1'b1, 1'b1);
`ifdef HANDSHAKE_RECV_BUFFER_CONST_MATCH_EN
    check("cm_count", {16'd0, match_count}, 32'd3);
    check("cm_mismatch", {31'd0, mismatch}, 32'd1);
`endif
    step(1'b1, '0, 1'b0, 1'b0);
`ifdef HANDSHAKE_RECV_BUFFER_CONST_MATCH_EN
    check("cm_count_rst", {16'd0, match_count}, 32'd0);
    check("cm_mismatch_rst", {31'd0, mismatch}, 32'd0);
`endif
    step(1'b0, '0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/handshake_recv_buffer.md
Name: handshake_recv_buffer

Overview:
- Two-slot elastic receiver on the team's valid/ready dataflow channel. It is the consuming end of a channel driven by producers such as constant, arith and mux units.
- Accepts data tokens on `ins` and re-presents them in order on `outs` with fully registered outputs. This cuts the combinational valid/ready path between producer and downstream unit.
- Sustains one token per cycle, and preserves token order.

Parameters:
- DATA_WIDTH, 32, width of the token payload in bits.
- CONST_VALUE, 0, expected payload value; used only when CONST_MATCH_EN is defined (truncated/zero-extended to DATA_WIDTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ins  input  DATA_WIDTH  incoming token payload.
- ins_valid  input  1  producer offers a token.
- ins_ready  output  1  buffer can accept a token this cycle.
- outs  output  DATA_WIDTH  head-of-buffer payload.
- outs_valid  output  1  head slot holds a token.
- outs_ready  input  1  consumer accepts the head token.
- mismatch  output  1  sticky flag; present only with CONST_MATCH_EN.
- match_count  output  16  count of accepted tokens equal to CONST_VALUE; present only with CONST_MATCH_EN.

Behaviour:
Handshake and transfers:
- Transfer in: `ins_valid && ins_ready` at a rising edge. Transfer out: `outs_valid && outs_ready` at a rising edge.
- State: slot0 (head), slot1 (tail), count in {0,1,2}.
- `ins_ready = (count != 2)`, derived from registers only; no combinational path from `outs_ready`.
- `outs_valid = (count != 0)` and `outs = slot0`, both registered state.
- `outs` is held stable while `outs_valid && !outs_ready`. Once offered, a token is never withdrawn.

Reset:
- When rst is high at an edge: count <= 0 and slot0 <= 0. Any transfer in or out during that cycle is discarded.
- After reset: `outs_valid = 0`, `outs = 0`, `ins_ready = 1`.
- Reset mid-operation drops all buffered tokens.

Transitions (push = transfer in, pop = transfer out):
- count 0, push: slot0 <= ins; count 1. `outs_valid` rises one cycle after acceptance (latency 1).
- count 1, push only: slot1 <= ins; count 2.
- count 1, pop only: count 0.
- count 1, push and pop: slot0 <= ins; count stays 1.
- count 2, pop only: slot0 <= slot1; count 1. `ins_ready` rises on the next cycle.
- count 2, push: not possible because `ins_ready = 0`.
- No push and no pop: state holds.

Throughput and ordering:
- Steady-state throughput is 1 token/cycle when `outs_ready` is held high.
- With `outs_ready` low, at most 2 tokens are absorbed, then `ins_ready` drops.
- FIFO order is strict.
- `ins` is ignored when `ins_valid` is low. X on `ins` while `ins_valid = 0` must not propagate into the slots.

Optional Feature:
Macro: HANDSHAKE_RECV_BUFFER_CONST_MATCH_EN.

When defined:
- Each accepted transfer in compares `ins` against CONST_VALUE[DATA_WIDTH-1:0].
- If equal: `match_count` increments, saturating at 16'hFFFF.
- If not equal: `mismatch` <= 1 and stays set until rst.
- Both outputs reset to 0 and are registered; they update the cycle after acceptance.
- Data path behaviour is unchanged.

When undefined:
- The `mismatch` and `match_count` ports and their logic are absent.
- The module is a pure 2-slot buffer.

Test Plan:
- Reset then idle: hold rst 2 cycles with `ins_valid = 1`, then deassert -> `outs_valid = 0`, `outs = 0`, `ins_ready = 1`, no token appears.
- Streaming, DATA_WIDTH=18: send 0x3FC4E, 0x00001, 0x2AAAA back-to-back with `outs_ready = 1` -> same values on `outs` on consecutive cycles, each 1 cycle after acceptance, `ins_ready` constantly 1.
- Backpressure: `outs_ready = 0`, offer 3 tokens A,B,C -> A and B accepted, `ins_ready = 0` after the second; C held. Raise `outs_ready` -> A, B, C delivered in order, `outs` stable while stalled.
- Simultaneous push/pop at count 1: alternate `outs_ready` randomly with continuous input -> no loss, no duplication, order preserved; compare against a scoreboard over 1000 tokens.
- Reset mid-operation with count 2 -> the next cycle shows `outs_valid = 0` and `ins_ready = 1`; the old tokens never appear.
- With CONST_MATCH_EN, CONST_VALUE=18'h3FC4E: send 0x3FC4E ×3 then 0x00000 -> `match_count = 3` and `mismatch = 1` one cycle after the fourth acceptance. After rst both are 0.
